// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler: round-robin packer of two AXI-Stream sources into fixed FRAME_BYTES UDP payloads.
// Define UDP_TX_SCHEDULER_SEQ_HDR_EN to prepend a {source, sequence} two-byte header.
module udp_tx_scheduler #(
  parameter int FRAME_BYTES = 88,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           s0_axis_tdata,
  input  logic                 s0_axis_tvalid,
  output logic                 s0_axis_tready,
  input  logic                 s0_axis_tlast,
  input  logic [7:0]           s1_axis_tdata,
  input  logic                 s1_axis_tvalid,
  output logic                 s1_axis_tready,
  input  logic                 s1_axis_tlast,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic                 m_axis_tready,
  output logic [1:0]           grant,
  output logic [CNT_WIDTH-1:0] pad_count,
  output logic [CNT_WIDTH-1:0] trunc_count
);
  localparam int CW = $clog2(FRAME_BYTES);
`ifdef UDP_TX_SCHEDULER_SEQ_HDR_EN
  typedef enum logic [2:0] {IDLE, HDR, DATA, PAD, DRAIN} state_t;
  logic [1:0][7:0] seq_q, seq_d;
`else
  typedef enum logic [2:0] {IDLE, DATA, PAD, DRAIN} state_t;
`endif
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sel_q, sel_d;
  logic [CNT_WIDTH-1:0] pad_q, pad_d, trunc_q, trunc_d;
  logic                 src_valid, src_last, gnt_rdy, at_end, hs;
  logic [7:0]           src_data;
  assign src_valid    = sel_q ? s1_axis_tvalid : s0_axis_tvalid;
  assign src_last     = sel_q ? s1_axis_tlast : s0_axis_tlast;
  assign src_data     = sel_q ? s1_axis_tdata : s0_axis_tdata;
  assign at_end       = cnt_q == CW'(FRAME_BYTES - 1);
  assign m_axis_tlast = at_end;
  assign m_axis_tuser = 1'b0;
  assign grant        = state_q == IDLE ? 2'b00 : (sel_q ? 2'b10 : 2'b01);
  assign pad_count    = pad_q;
  assign trunc_count  = trunc_q;
  assign hs           = m_axis_tvalid & m_axis_tready;
  assign s0_axis_tready = gnt_rdy & ~sel_q;
  assign s1_axis_tready = gnt_rdy & sel_q;
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    pad_d         = pad_q;
    trunc_d       = trunc_q;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    gnt_rdy       = 1'b0;
    case (state_q)
      IDLE: if (s0_axis_tvalid | s1_axis_tvalid) begin
        // sel_q doubles as the last-granted source for round-robin
        sel_d = (s0_axis_tvalid & s1_axis_tvalid) ? ~sel_q : s1_axis_tvalid;
`ifdef UDP_TX_SCHEDULER_SEQ_HDR_EN
        state_d = HDR;
`else
        state_d = DATA;
`endif
      end
`ifdef UDP_TX_SCHEDULER_SEQ_HDR_EN
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = cnt_q == '0 ? {7'b0, sel_q} : seq_q[sel_q];
        if (m_axis_tready && cnt_q == CW'(1)) state_d = DATA;
      end
`endif
      DATA: begin
        m_axis_tvalid = src_valid;
        m_axis_tdata  = src_data;
        gnt_rdy       = m_axis_tready;
        if (src_valid && m_axis_tready) begin
          if (at_end) begin
            state_d = src_last ? IDLE : DRAIN;
            if (!src_last && ~&trunc_q) trunc_d = trunc_q + CNT_WIDTH'(1);
          end else if (src_last) begin
            state_d = PAD;
            if (~&pad_q) pad_d = pad_q + CNT_WIDTH'(1);
          end
        end
      end
      PAD: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready && at_end) state_d = IDLE;
      end
      DRAIN: begin
        gnt_rdy = 1'b1;
        if (src_valid && src_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d = hs ? (at_end ? '0 : cnt_q + CW'(1)) : cnt_q;
`ifdef UDP_TX_SCHEDULER_SEQ_HDR_EN
    seq_d = seq_q;
    if (hs && at_end) seq_d[sel_q] = seq_q[sel_q] + 8'd1;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b1;
      pad_q   <= '0;
      trunc_q <= '0;
`ifdef UDP_TX_SCHEDULER_SEQ_HDR_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      pad_q   <= pad_d;
      trunc_q <= trunc_d;
`ifdef UDP_TX_SCHEDULER_SEQ_HDR_EN
      seq_q   <= seq_d;
`endif
    end
  end
endmodule

// File: tb/tb_udp_tx_scheduler.sv
// tb_udp_tx_scheduler: directed frame table plus arbitration, reset and header sequences.
module tb_udp_tx_scheduler;
  localparam int FB = 88;
`ifdef UDP_TX_SCHEDULER_SEQ_HDR_EN
  localparam int HB = 2;
`else
  localparam int HB = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] s0_tdata = 0, s1_tdata = 0, m_tdata;
  logic s0_tvalid = 0, s0_tready, s0_tlast = 0;
  logic s1_tvalid = 0, s1_tready, s1_tlast = 0;
  logic m_tvalid, m_tlast, m_tuser, m_tready = 0;
  logic [1:0] grant;
  logic [15:0] pad_count, trunc_count;
  int n_chk = 0, n_fail = 0, exp_pad = 0, exp_trunc = 0;
  logic [7:0] seq [2];
  always #5 clk = ~clk;

  udp_tx_scheduler #(.FRAME_BYTES(FB), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready), .s0_axis_tlast(s0_tlast),
    .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready), .s1_axis_tlast(s1_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .m_axis_tready(m_tready), .grant(grant), .pad_count(pad_count), .trunc_count(trunc_count));

  typedef struct { int src; int len; int base; logic [3:0] pat; bit pad; bit trunc; } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int src, input logic v, input logic [7:0] d, input logic l);
    s0_tvalid = src == 0 && v; s0_tdata = src == 0 ? d : 8'h00; s0_tlast = src == 0 && l;
    s1_tvalid = src == 1 && v; s1_tdata = src == 1 ? d : 8'h00; s1_tlast = src == 1 && l;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 0; drive(0, 0, 0, 0); m_tready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    exp_pad = 0; exp_trunc = 0; seq[0] = 0; seq[1] = 0;
  endtask

  function automatic logic [7:0] exp_byte(input int src, input int len, input int base, input int i);
    if (i < HB) return i == 0 ? 8'(src) : seq[src];
    return (i - HB < len) ? 8'(base + i - HB) : 8'h00;
  endfunction

  task automatic idle_check(input string nm);
    @(negedge clk);
    drive(0, 0, 0, 0); m_tready = 1;
    #1;
    chk({nm, " idle tvalid"}, m_tvalid, 0);
    chk({nm, " idle grant"}, grant, 0);
    chk({nm, " idle treadys"}, {s0_tready, s1_tready}, 0);
    chk({nm, " pad_count"}, pad_count, exp_pad);
    chk({nm, " trunc_count"}, trunc_count, exp_trunc);
  endtask

  task automatic run_frame(input int src, input int len, input int base, input logic [3:0] pat,
                           input bit pinc, input bit tinc, input string nm);
    logic [7:0] obuf [FB];
    bit olast [FB];
    int sp = 0, oc = 0, cyc = 0, stall_err = 0, derr = 0, lerr = 0;
    logic pv = 0, pl = 0, v;
    logic [7:0] pd = 0;
    logic [1:0] g = 0;
    while (!(oc >= FB && sp >= len) && cyc < 2000) begin
      @(negedge clk);
      v = sp < len;
      drive(src, v, 8'(base + sp), sp == len - 1);
      m_tready = pat[cyc % 4];
      #1;
      if (pv && (!m_tvalid || m_tdata !== pd || m_tlast !== pl)) stall_err++;
      pv = m_tvalid && !m_tready; pd = m_tdata; pl = m_tlast;
      if (m_tvalid && m_tready) begin
        if (oc < FB) begin obuf[oc] = m_tdata; olast[oc] = m_tlast; end
        oc++;
      end
      if (g == 0 && grant != 0) g = grant;
      if (v && (src == 1 ? s1_tready : s0_tready)) sp++;
      cyc++;
    end
    chk({nm, " out bytes"}, oc, FB);
    for (int i = 0; i < oc && i < FB; i++) begin
      if (obuf[i] !== exp_byte(src, len, base, i)) derr++;
      if (olast[i] !== (i == FB - 1)) lerr++;
    end
    chk({nm, " data errs"}, derr, 0);
    chk({nm, " tlast errs"}, lerr, 0);
    chk({nm, " stall errs"}, stall_err, 0);
    chk({nm, " grant"}, g, src == 1 ? 2'b10 : 2'b01);
    exp_pad += int'(pinc); exp_trunc += int'(tinc); seq[src]++;
    idle_check(nm);
  endtask

  int gs [$];
  logic [1:0] pg;

  initial begin
    tbl[0] = '{0, FB - HB, 8'h00, 4'b1111, 0, 0};
    tbl[1] = '{0, 10, 8'h20, 4'b1111, 1, 0};
    tbl[2] = '{1, 100, 8'h40, 4'b1111, 0, 1};
    tbl[3] = '{0, 20, 8'h80, 4'b1001, 1, 0};
    tbl[4] = '{1, FB - HB + 1, 8'hA0, 4'b0110, 0, 1};
    tbl[5] = '{1, FB - HB - 1, 8'h10, 4'b1101, 1, 0};
    tbl[6] = '{0, 1, 8'hEE, 4'b0011, 1, 0};
    reset_dut();
    #1;
    chk("reset tvalid", m_tvalid, 0);
    chk("reset tlast", m_tlast, 0);
    chk("reset grant", grant, 0);
    chk("reset treadys", {s0_tready, s1_tready}, 0);
    chk("reset counters", {pad_count, trunc_count}, 0);
    chk("tuser", m_tuser, 0);
    for (int i = 0; i < 7; i++)
      run_frame(tbl[i].src, tbl[i].len, tbl[i].base, tbl[i].pat, tbl[i].pad, tbl[i].trunc, $sformatf("vec%0d", i));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(0, 1, 8'(i), 0); m_tready = 1;
    end
    #1;
    chk("midframe grant", grant, 2'b01);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    #1;
    chk("rst grant", grant, 0);
    chk("rst tvalid", m_tvalid, 0);
    chk("rst tlast", m_tlast, 0);
    chk("rst s0_tready", s0_tready, 0);
    chk("rst counters", {pad_count, trunc_count}, 0);
    @(negedge clk);
    drive(0, 0, 0, 0); rst_n = 1;
    exp_pad = 0; exp_trunc = 0; seq[0] = 0; seq[1] = 0;
    pg = 0;
    for (int c = 0; c < 2000 && gs.size() < 4; c++) begin
      @(negedge clk);
      s0_tvalid = 1; s1_tvalid = 1; s0_tlast = 1; s1_tlast = 1;
      s0_tdata = 8'h11; s1_tdata = 8'h22; m_tready = 1;
      #1;
      if (grant != 0 && pg == 0) gs.push_back(grant);
      pg = grant;
    end
    chk("arb grants seen", gs.size(), 4);
    for (int i = 0; i < gs.size(); i++)
      chk($sformatf("arb grant %0d", i), gs[i], i % 2 == 0 ? 2'b01 : 2'b10);
    reset_dut();
    run_frame(1, 30, 8'h55, 4'b1111, 1, 0, "post-reset");
`ifdef UDP_TX_SCHEDULER_SEQ_HDR_EN
    for (int i = 0; i < 257; i++)
      run_frame(0, 4, i, 4'b1111, 1, 0, $sformatf("hdr%0d", i));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
